// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit sll/srl/sra datapath.
// One operation in flight; the result is held on the granted requester's channel until accepted.
module shift_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [4:0]       req_b0,
    input  logic [4:0]       req_b1,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;

    state_t           r_state;
    logic             r_prio;
    logic             r_gnt;
    logic [WIDTH-1:0] r_a;
    logic [4:0]       r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_res;
    logic [1:0]       r_rsp_valid;
    logic             r_busy;

    logic             w_grant;
    logic [1:0]       w_req_ready;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_result;

    // Result select; op 11 passes the operand through untouched.
    function automatic logic [WIDTH-1:0] select_result(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] sll_v,
        input logic [WIDTH-1:0] srl_v,
        input logic [WIDTH-1:0] sra_v
    );
        logic [WIDTH-1:0] res;
        case (op)
            OP_SLL:  res = sll_v;
            OP_SRL:  res = srl_v;
            OP_SRA:  res = sra_v;
            default: res = a;
        endcase
        return res;
    endfunction

    // Shared shift units, fed only from the latched operands.
    always_comb begin
        w_sll    = r_a << r_b;
        w_srl    = r_a >> r_b;
        w_sra    = WIDTH'($signed(r_a) >>> r_b);
        w_result = select_result(r_op, r_a, w_sll, w_srl, w_sra);
    end

    // Grant selection: a lone requester wins, a tie goes to r_prio.
    always_comb begin
        w_grant = 1'b0;
        if (req_valid == 2'b10) begin
            w_grant = 1'b1;
        end else if (req_valid == 2'b11) begin
            w_grant = r_prio;
        end else begin
            w_grant = 1'b0;
        end
    end

    // Ready is offered only in IDLE and only to the granted requester; forced low under reset.
    always_comb begin
        w_req_ready = 2'b00;
        if (rst_n && (r_state == IDLE) && (|req_valid)) begin
            w_req_ready = w_grant ? 2'b10 : 2'b01;
        end else begin
            w_req_ready = 2'b00;
        end
    end

    // Control FSM with registered response/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_gnt       <= 1'b0;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= 5'd0;
            r_op        <= 2'b00;
            r_res       <= {WIDTH{1'b0}};
            r_rsp_valid <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_gnt   <= w_grant;
                        r_prio  <= ~w_grant;
                        r_a     <= w_grant ? req_a1  : req_a0;
                        r_b     <= w_grant ? req_b1  : req_b0;
                        r_op    <= w_grant ? req_op1 : req_op0;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_res       <= w_result;
                    r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                    r_state     <= RESP;
                end
                RESP: begin
                    // Only the granted requester's ready can retire the response.
                    if (rsp_ready[r_gnt]) begin
                        r_rsp_valid <= 2'b00;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_res;
    assign busy       = r_busy;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter: reset, op coverage, round-robin,
// back-pressure and wrong-requester ready.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_a0 = 32'd0;
    logic [31:0] req_a1 = 32'd0;
    logic [4:0]  req_b0 = 5'd0;
    logic [4:0]  req_b1 = 5'd0;
    logic [1:0]  req_op0 = 2'b00;
    logic [1:0]  req_op1 = 2'b00;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_result;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    shift_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_result !== 32'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b valid=%b result=%h busy=%b, want 00/00/0/0",
                     req_ready, rsp_valid, rsp_result, busy);
        end
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        req_a0 = 32'h8000_0010; req_b0 = 5'd4; req_op0 = 2'b10;
        req_valid = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_ready: got ready=%b busy=%b, want 01/0", req_ready, busy);
        end
        tick();
        req_valid = 2'b00;
        req_a0 = 32'hDEAD_BEEF; req_op0 = 2'b00;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL single_exec: got busy=%b valid=%b ready=%b, want 1/00/00", busy, rsp_valid, req_ready);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b1 || rsp_valid !== 2'b01 || rsp_result !== 32'hF800_0001) begin
            n_err++;
            $display("FAIL single_resp: got busy=%b valid=%b result=%h, want 1/01/f8000001",
                     busy, rsp_valid, rsp_result);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            n_err++;
            $display("FAIL single_done: got busy=%b valid=%b, want 0/00", busy, rsp_valid);
        end
    endtask

    task automatic test_ops();
        logic [1:0]  ops [8]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [4:0]  amts [8] = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [31:0] exps [8] = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0001,
                                  32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            int waited;
            req_a1 = 32'h8000_0001; req_b1 = amts[k]; req_op1 = ops[k];
            req_valid = 2'b10;
            #1;
            n_cmp++;
            if (req_ready !== 2'b10) begin
                n_err++;
                $display("FAIL ops_ready[%0d]: got %b, want 10", k, req_ready);
            end
            tick();
            req_valid = 2'b00;
            waited = 0;
            while (rsp_valid === 2'b00 && waited < 6) begin
                tick();
                waited++;
            end
            n_cmp++;
            if (rsp_valid !== 2'b10 || rsp_result !== exps[k]) begin
                n_err++;
                $display("FAIL ops_result[%0d]: got valid=%b result=%h, want 10/%h",
                         k, rsp_valid, rsp_result, exps[k]);
            end
            rsp_ready = 2'b10;
            tick();
            rsp_ready = 2'b00;
        end
    endtask

    task automatic test_round_robin();
        int n_acc = 0;
        logic last_g = 1'b0;
        tick();
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        tick();
        req_a0 = 32'h0000_0011; req_op0 = 2'b11; req_b0 = 5'd3;
        req_a1 = 32'h0000_0022; req_op1 = 2'b11; req_b1 = 5'd7;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        rst_n = 1'b1;
        #1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (req_ready !== 2'b00) begin
                logic [1:0] exp_r;
                exp_r = n_acc[0] ? 2'b10 : 2'b01;
                n_cmp++;
                if (req_ready !== exp_r || cyc != 3 * n_acc) begin
                    n_err++;
                    $display("FAIL rr_grant: got ready=%b at cycle %0d, want %b at cycle %0d",
                             req_ready, cyc, exp_r, 3 * n_acc);
                end
                last_g = n_acc[0];
                n_acc++;
            end
            if (rsp_valid !== 2'b00) begin
                n_cmp++;
                if (rsp_valid !== (last_g ? 2'b10 : 2'b01) ||
                    rsp_result !== (last_g ? 32'h0000_0022 : 32'h0000_0011)) begin
                    n_err++;
                    $display("FAIL rr_resp: got valid=%b result=%h for grant %0d", rsp_valid, rsp_result, last_g);
                end
            end
            tick();
        end
        n_cmp++;
        if (n_acc != 4) begin
            n_err++;
            $display("FAIL rr_count: got %0d accepts, want 4", n_acc);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    task automatic test_back_pressure();
        do_reset();
        req_a0 = 32'h1234_5678; req_b0 = 5'd4; req_op0 = 2'b01;
        req_a1 = 32'h0000_00F0; req_b1 = 5'd2; req_op1 = 2'b11;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        #1;
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL bp_exec_ready: got %b, want 00", req_ready);
        end
        tick();
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (rsp_valid !== 2'b01 || rsp_result !== 32'h0123_4567 || req_ready !== 2'b00 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got valid=%b result=%h ready=%b busy=%b, want 01/01234567/00/1",
                         c, rsp_valid, rsp_result, req_ready, busy);
            end
            tick();
        end
        rsp_ready = 2'b01;
        #1;
        n_cmp++;
        if (rsp_valid !== 2'b01 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL bp_release: got valid=%b ready=%b, want 01/00", rsp_valid, req_ready);
        end
        tick();
        rsp_ready = 2'b00;
        n_cmp++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL bp_next_grant: got valid=%b ready=%b, want 00/10", rsp_valid, req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        n_cmp++;
        if (rsp_valid !== 2'b10 || rsp_result !== 32'h0000_00F0) begin
            n_err++;
            $display("FAIL bp_second: got valid=%b result=%h, want 10/000000f0", rsp_valid, rsp_result);
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_wrong_ready();
        do_reset();
        req_a0 = 32'h0000_CAFE; req_b0 = 5'd1; req_op0 = 2'b00;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        rsp_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 2'b01 || busy !== 1'b1 || rsp_result !== 32'h0001_95FC) begin
                n_err++;
                $display("FAIL wrong_ready[%0d]: got valid=%b busy=%b result=%h, want 01/1/000195fc",
                         c, rsp_valid, busy, rsp_result);
            end
        end
        rsp_ready = 2'b11;
        tick();
        rsp_ready = 2'b00;
        n_cmp++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL wrong_ready_exit: got valid=%b busy=%b, want 00/0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid_resp();
        do_reset();
        req_a0 = 32'h0000_0005; req_b0 = 5'd1; req_op0 = 2'b00;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_async: got valid=%b busy=%b result=%h, want 00/0/0", rsp_valid, busy, rsp_result);
        end
        tick();
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL reset_prio: got ready=%b, want 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tick();
        tick();
        rsp_ready = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_ops();
        test_round_robin();
        test_back_pressure();
        test_wrong_ready();
        test_reset_mid_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
